adder_arbiter: RTL and testbench

- Shares one 8-bit adder datapath among NUM_REQ requesters (e.g. PC increment, ALU add, address offset) using round-robin arbitration.
- Latches the winner's operands, computes the sum in a registered stage and returns it with a one-cycle ack to the winning requester.
- Sits between the datapath request sources and the single shared adder instance.

---
 rtl/adder_arb_pkg.sv | 12 +
 rtl/adder_arbiter_rr_pick.sv | 33 +++
 rtl/adder_arbiter.sv | 129 ++++++++++++
 tb/tb_adder_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// Shared definitions for the adder arbiter: datapath width and FSM encoding.
package adder_arb_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/adder_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Scans req starting one above
// last_grant, wrapping at NUM_REQ, and returns the first set bit.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] sel,
  output logic [ID_W-1:0]    sel_id,
  output logic               any
);

  int start;

  // Walk the requesters in rotated order; the first hit wins.
  always_comb begin
    start  = (int'(last_grant) + 1) % NUM_REQ;
    sel_id = '0;
    any    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!any && req[j] && (j == (start + i) % NUM_REQ)) begin
          any    = 1'b1;
          sel_id = ID_W'(j);
        end
      end
    end
  end

  assign sel = any ? (NUM_REQ'(1) << sel_id) : '0;

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one 8-bit adder among NUM_REQ requesters with
// round-robin arbitration, a registered sum and a one-cycle ack.
// Optional macro ADDER_ARB_FLAGS_EN adds registered carry and ovf outputs.
//
// state | meaning
// IDLE  | waiting for req; arbitrate and latch operands when any req is set
// EXEC  | grant high; shared adder works on latched operands, sum captured
// RESP  | ack high for one cycle with result valid; no arbitration
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [DATA_W*NUM_REQ-1:0] in1_bus,
  input  logic [DATA_W*NUM_REQ-1:0] in2_bus,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         result,
  output logic [ID_W-1:0]           result_id,
`ifdef ADDER_ARB_FLAGS_EN
  output logic                      carry,
  output logic                      ovf,
`endif
  output logic                      busy
);

  state_t state, state_nxt;

  logic [ID_W-1:0]    last_grant;
  logic [NUM_REQ-1:0] sel;
  logic [ID_W-1:0]    sel_id;
  logic               any;
  logic [DATA_W-1:0]  op1, op2;
  logic [DATA_W-1:0]  pick1, pick2;
  logic [NUM_REQ-1:0] id_hot;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_rr_pick (
    .req       (req),
    .last_grant(last_grant),
    .sel       (sel),
    .sel_id    (sel_id),
    .any       (any)
  );

  // The single shared adder; the carry bit is only kept when flags exist.
`ifdef ADDER_ARB_FLAGS_EN
  logic [DATA_W:0] sum;
  assign sum = {1'b0, op1} + {1'b0, op2};
`else
  logic [DATA_W-1:0] sum;
  assign sum = op1 + op2;
`endif

  // Operand mux driven by the one-hot pick.
  always_comb begin
    pick1 = '0;
    pick2 = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (sel[j]) begin
        pick1 = in1_bus[j*DATA_W +: DATA_W];
        pick2 = in2_bus[j*DATA_W +: DATA_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers: operand latch on arbitration, result capture in EXEC.
  always_ff @(posedge clock) begin
    if (reset) begin
      op1        <= '0;
      op2        <= '0;
      result     <= '0;
      result_id  <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
`ifdef ADDER_ARB_FLAGS_EN
      carry      <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else begin
      if (state == IDLE && any) begin
        op1       <= pick1;
        op2       <= pick2;
        result_id <= sel_id;
      end
      if (state == EXEC) begin
        result     <= sum[DATA_W-1:0];
        last_grant <= result_id;
`ifdef ADDER_ARB_FLAGS_EN
        carry      <= sum[DATA_W];
        ovf        <= (op1[DATA_W-1] == op2[DATA_W-1]) &&
                      (sum[DATA_W-1] != op1[DATA_W-1]);
`endif
      end
    end
  end

  assign id_hot = NUM_REQ'(1) << result_id;

  // Outputs decoded from state; result_id identifies the owner throughout.
  always_comb begin
    grant = (state == EXEC) ? id_hot : '0;
    ack   = (state == RESP) ? id_hot : '0;
    busy  = (state != IDLE);
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter (NUM_REQ=3).
// Inputs are driven and outputs sampled on the falling edge.
module tb_adder_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [23:0] in1_bus, in2_bus;
  logic [2:0]  grant, ack;
  logic [7:0]  result;
  logic [1:0]  result_id;
  logic        busy;
`ifdef ADDER_ARB_FLAGS_EN
  logic        carry, ovf;
`endif

  int errors = 0;
  int checks = 0;

  adder_arbiter #(.NUM_REQ(3), .ID_W(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .in1_bus  (in1_bus),
    .in2_bus  (in2_bus),
    .grant    (grant),
    .ack      (ack),
    .result   (result),
    .result_id(result_id),
`ifdef ADDER_ARB_FLAGS_EN
    .carry    (carry),
    .ovf      (ovf),
`endif
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    in1_bus[i*8 +: 8] = a;
    in2_bus[i*8 +: 8] = b;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req   = 3'b000;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    req     = 3'b000;
    in1_bus = '0;
    in2_bus = '0;
    tick;
    tick;
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL reset_grant got=%b exp=000", grant); end
    checks++; if (ack !== 3'b000) begin errors++; $display("FAIL reset_ack got=%b exp=000", ack); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result got=%h exp=00", result); end
    checks++; if (result_id !== 2'd0) begin errors++; $display("FAIL reset_result_id got=%0d exp=0", result_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b0;
    tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single;
    set_op(0, 8'h12, 8'h34);
    req = 3'b001;
    tick;
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL single_grant got=%b exp=001", grant); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    checks++; if (ack !== 3'b000) begin errors++; $display("FAIL single_early_ack got=%b exp=000", ack); end
    tick;
    checks++; if (ack !== 3'b001) begin errors++; $display("FAIL single_ack got=%b exp=001", ack); end
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL single_grant_clr got=%b exp=000", grant); end
    checks++; if (result !== 8'h46) begin errors++; $display("FAIL single_result got=%h exp=46", result); end
    checks++; if (result_id !== 2'd0) begin errors++; $display("FAIL single_result_id got=%0d exp=0", result_id); end
    req = 3'b000;
    tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_low got=%b exp=0", busy); end
    checks++; if (ack !== 3'b000) begin errors++; $display("FAIL single_ack_pulse got=%b exp=000", ack); end
    checks++; if (result !== 8'h46) begin errors++; $display("FAIL single_result_hold got=%h exp=46", result); end
  endtask

  task automatic test_round_robin;
    logic [7:0] exp_sum [3];
    exp_sum[0] = 8'h03;
    exp_sum[1] = 8'h30;
    exp_sum[2] = 8'h10;
    do_reset;
    set_op(0, 8'h01, 8'h02);
    set_op(1, 8'h10, 8'h20);
    set_op(2, 8'h80, 8'h90);
    req = 3'b111;
    for (int n = 0; n < 3; n++) begin
      tick;
      checks++; if (grant !== (3'b001 << n)) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", n, grant, 3'b001 << n); end
      tick;
      checks++; if (ack !== (3'b001 << n)) begin errors++; $display("FAIL rr_ack%0d got=%b exp=%b", n, ack, 3'b001 << n); end
      checks++; if (result !== exp_sum[n]) begin errors++; $display("FAIL rr_result%0d got=%h exp=%h", n, result, exp_sum[n]); end
      checks++; if (result_id !== 2'(n)) begin errors++; $display("FAIL rr_result_id%0d got=%0d exp=%0d", n, result_id, n); end
      req[n] = 1'b0;
      tick;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle%0d got=%b exp=0", n, busy); end
    end
  endtask

  task automatic test_wrap;
    set_op(0, 8'hF0, 8'h20);
    req = 3'b001;
    tick;
    tick;
    checks++; if (ack !== 3'b001) begin errors++; $display("FAIL wrap_ack got=%b exp=001", ack); end
    checks++; if (result !== 8'h10) begin errors++; $display("FAIL wrap_result got=%h exp=10", result); end
`ifdef ADDER_ARB_FLAGS_EN
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL wrap_carry got=%b exp=1", carry); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL wrap_ovf got=%b exp=0", ovf); end
`endif
    req = 3'b000;
    tick;
    set_op(1, 8'h7F, 8'h01);
    req = 3'b010;
    tick;
    tick;
    checks++; if (ack !== 3'b010) begin errors++; $display("FAIL ovf_ack got=%b exp=010", ack); end
    checks++; if (result !== 8'h80) begin errors++; $display("FAIL ovf_result got=%h exp=80", result); end
`ifdef ADDER_ARB_FLAGS_EN
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL ovf_carry got=%b exp=0", carry); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_ovf got=%b exp=1", ovf); end
`endif
    req = 3'b000;
    tick;
`ifdef ADDER_ARB_FLAGS_EN
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_hold got=%b exp=1", ovf); end
`endif
  endtask

  task automatic test_latch;
    set_op(0, 8'h05, 8'h06);
    req = 3'b001;
    tick;
    checks++; if (grant !== 3'b001) begin errors++; $display("FAIL latch_grant got=%b exp=001", grant); end
    set_op(0, 8'hFF, 8'hFF);
    req = 3'b000;
    tick;
    checks++; if (ack !== 3'b001) begin errors++; $display("FAIL latch_ack got=%b exp=001", ack); end
    checks++; if (result !== 8'h0B) begin errors++; $display("FAIL latch_result got=%h exp=0b", result); end
    tick;
  endtask

  task automatic test_reset_mid;
    set_op(2, 8'h11, 8'h22);
    req = 3'b100;
    tick;
    checks++; if (grant !== 3'b100) begin errors++; $display("FAIL mid_grant got=%b exp=100", grant); end
    reset = 1'b1;
    tick;
    checks++; if (ack !== 3'b000) begin errors++; $display("FAIL mid_ack got=%b exp=000", ack); end
    checks++; if (grant !== 3'b000) begin errors++; $display("FAIL mid_grant_clr got=%b exp=000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL mid_result got=%h exp=00", result); end
    checks++; if (result_id !== 2'd0) begin errors++; $display("FAIL mid_result_id got=%0d exp=0", result_id); end
    reset = 1'b0;
    set_op(1, 8'h21, 8'h43);
    req = 3'b110;
    tick;
    checks++; if (grant !== 3'b010) begin errors++; $display("FAIL mid_regrant got=%b exp=010", grant); end
    tick;
    checks++; if (ack !== 3'b010) begin errors++; $display("FAIL mid_reack got=%b exp=010", ack); end
    checks++; if (result !== 8'h64) begin errors++; $display("FAIL mid_reresult got=%h exp=64", result); end
    req = 3'b000;
    tick;
  endtask

  task automatic test_starvation;
    logic [2:0] exp_grant [6];
    logic [2:0] got;
    int since2;
    exp_grant[0] = 3'b100;
    exp_grant[1] = 3'b100;
    exp_grant[2] = 3'b001;
    exp_grant[3] = 3'b100;
    exp_grant[4] = 3'b001;
    exp_grant[5] = 3'b100;
    set_op(0, 8'h01, 8'h01);
    set_op(2, 8'h02, 8'h02);
    since2 = 0;
    for (int n = 0; n < 6; n++) begin
      req = {1'b1, 1'b0, ((n % 2) == 0) ? 1'b1 : 1'b0};
      tick;
      got = grant;
      checks++; if (got !== exp_grant[n]) begin errors++; $display("FAIL starve_grant%0d got=%b exp=%b", n, got, exp_grant[n]); end
      since2 = (got === 3'b100) ? 0 : since2 + 1;
      checks++; if (since2 >= 2) begin errors++; $display("FAIL starve_window%0d got=%0d exp<2", n, since2); end
      tick;
      checks++; if (ack !== exp_grant[n]) begin errors++; $display("FAIL starve_ack%0d got=%b exp=%b", n, ack, exp_grant[n]); end
      tick;
    end
    req = 3'b000;
    tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_wrap;
    test_latch;
    test_reset_mid;
    test_starvation;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
